writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile.sv | 103 ++++++++++
 tb/tb_writeback_regfile.sv | 120 ++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage and architectural register file with sticky status and a retired-instruction counter.
// Writes land on the wb_en edge and are visible the next cycle with no bypass; there is no backpressure, wb_en is the only strobe.
module writeback_regfile #(
  parameter logic [63:0] STACK_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [63:0] reg0,
  output logic [63:0] reg1,
  output logic [63:0] reg2,
  output logic [63:0] reg3,
  output logic [63:0] reg4,
  output logic [63:0] reg5,
  output logic [63:0] reg6,
  output logic [63:0] reg7,
  output logic [63:0] reg8,
  output logic [63:0] reg9,
  output logic [63:0] reg10,
  output logic [63:0] reg11,
  output logic [63:0] reg12,
  output logic [63:0] reg13,
  output logic [63:0] reg14,
  output logic [1:0]  stat,
  output logic [63:0] retired
);

  typedef enum logic [1:0] {
    S_AOK = 2'd1,
    S_HLT = 2'd2,
    S_INS = 2'd3
  } stat_t;

  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] R_RSP  = 4'd4;

  stat_t       state;
  logic [63:0] regs [15];
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic        commit;

  always_comb begin
    dst_e = R_NONE;
    dst_m = R_NONE;
    case (icode)
      4'h2:                   dst_e = cnd ? rB : R_NONE;
      4'h3, 4'h6:             dst_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = R_RSP;
      default:                dst_e = R_NONE;
    endcase
    case (icode)
      4'h5, 4'hB: dst_m = rA;
      default:    dst_m = R_NONE;
    endcase
  end

  assign commit = wb_en && (state == S_AOK);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? STACK_INIT : 64'd0;
      end
      state   <= S_AOK;
      retired <= 64'd0;
    end else if (commit) begin
      if (icode <= 4'hB) begin
        retired <= retired + 64'd1;
        if (dst_e != R_NONE) regs[dst_e] <= valE;
        // M port is written last so it wins when both ports target the same register.
        if (dst_m != R_NONE) regs[dst_m] <= valM;
        if (icode == 4'h0) state <= S_HLT;
      end else begin
        state <= S_INS;
      end
    end
  end

  assign stat  = state;
  assign reg0  = regs[0];
  assign reg1  = regs[1];
  assign reg2  = regs[2];
  assign reg3  = regs[3];
  assign reg4  = regs[4];
  assign reg5  = regs[5];
  assign reg6  = regs[6];
  assign reg7  = regs[7];
  assign reg8  = regs[8];
  assign reg9  = regs[9];
  assign reg10 = regs[10];
  assign reg11 = regs[11];
  assign reg12 = regs[12];
  assign reg13 = regs[13];
  assign reg14 = regs[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized bench for writeback_regfile, checked against an instruction-level model of Y86-64 writeback.
module tb_writeback_regfile;

  localparam logic [63:0] SI = 64'h100;

  logic        clk = 1'b0;
  logic        rst, wb_en, cnd;
  logic [3:0]  icode, rA, rB;
  logic [63:0] valE, valM;
  logic [63:0] r_out [15];
  logic [1:0]  stat;
  logic [63:0] retired;

  logic [63:0] m_regs [15];
  int          m_stat;
  logic [63:0] m_retired;
  int          n_vec  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  writeback_regfile #(.STACK_INIT(SI)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .icode(icode), .cnd(cnd),
    .rA(rA), .rB(rB), .valE(valE), .valM(valM),
    .reg0(r_out[0]), .reg1(r_out[1]), .reg2(r_out[2]), .reg3(r_out[3]),
    .reg4(r_out[4]), .reg5(r_out[5]), .reg6(r_out[6]), .reg7(r_out[7]),
    .reg8(r_out[8]), .reg9(r_out[9]), .reg10(r_out[10]), .reg11(r_out[11]),
    .reg12(r_out[12]), .reg13(r_out[13]), .reg14(r_out[14]),
    .stat(stat), .retired(retired)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one clock edge, stated instruction by instruction.
  task automatic model_edge(input logic r, input logic w, input logic [3:0] ic, input logic c,
                            input logic [3:0] a, input logic [3:0] b,
                            input logic [63:0] e, input logic [63:0] m);
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 64'd0;
      m_regs[4] = SI;
      m_stat    = 1;
      m_retired = 64'd0;
    end else if (w && m_stat == 1) begin
      if (ic > 4'hB) begin
        m_stat = 3;
      end else begin
        m_retired = m_retired + 1;
        if (ic == 4'h0) m_stat = 2;
        if ((ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) && b != 4'hF) m_regs[b] = e;
        if (ic >= 4'h8) m_regs[4] = e;
        if ((ic == 4'h5 || ic == 4'hB) && a != 4'hF) m_regs[a] = m;
      end
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] ic, input logic c,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [63:0] e, input logic [63:0] m);
    @(negedge clk);
    rst = r; wb_en = w; icode = ic; cnd = c; rA = a; rB = b; valE = e; valM = m;
    @(posedge clk);
    model_edge(r, w, ic, c, a, b, e, m);
    #1;
    for (int i = 0; i < 15; i++) chk($sformatf("reg%0d", i), r_out[i], m_regs[i]);
    chk("stat", {62'd0, stat}, 64'(m_stat));
    chk("retired", retired, m_retired);
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; icode = 4'h1; cnd = 1'b0;
    rA = 4'hF; rB = 4'hF; valE = 64'd0; valM = 64'd0;

    // Reset with a competing write on the same edge.
    step(1, 1, 4'h3, 0, 4'hF, 4'd5, 64'hFFFF, 64'd0);
    step(0, 1, 4'h3, 0, 4'hF, 4'd9, 64'h1234, 64'd0);
    step(0, 1, 4'h2, 0, 4'hF, 4'd9, 64'h55, 64'd0);
    step(0, 1, 4'h2, 1, 4'hF, 4'd7, 64'h77, 64'd0);
    step(0, 1, 4'hB, 0, 4'd4, 4'hF, 64'h108, 64'hDEAD);
    step(0, 1, 4'hB, 0, 4'd3, 4'hF, 64'h110, 64'hBEEF);
    step(0, 0, 4'h6, 0, 4'hF, 4'd2, 64'd7, 64'd0);
    step(0, 1, 4'h6, 0, 4'hF, 4'd2, 64'd7, 64'd0);
    step(0, 1, 4'h5, 0, 4'd6, 4'hF, 64'h66, 64'hCAFE);
    step(0, 1, 4'h8, 0, 4'd1, 4'd1, 64'hF8, 64'h11);
    step(0, 1, 4'h1, 1, 4'd2, 4'd2, 64'h99, 64'h99);
    step(0, 1, 4'h3, 0, 4'hF, 4'hF, 64'h99, 64'h99);
    step(0, 1, 4'h0, 0, 4'hF, 4'd1, 64'h99, 64'h99);
    step(0, 1, 4'h3, 0, 4'hF, 4'd1, 64'h99, 64'h99);
    step(1, 1, 4'h0, 0, 4'hF, 4'hF, 64'd0, 64'd0);
    step(0, 1, 4'h3, 0, 4'hF, 4'd8, 64'hABC, 64'd0);
    step(0, 1, 4'hE, 0, 4'd2, 4'd2, 64'h5, 64'h6);
    step(0, 1, 4'h3, 0, 4'hF, 4'd8, 64'h777, 64'd0);
    step(1, 1, 4'h3, 0, 4'hF, 4'd8, 64'h888, 64'd0);

    for (int k = 0; k < 400; k++) begin
      logic        r, w, c;
      logic [3:0]  ic, a, b;
      int          roll;
      roll = $urandom_range(0, 99);
      if (roll < 2)      ic = 4'h0;
      else if (roll < 4) ic = 4'(12 + $urandom_range(0, 3));
      else               ic = 4'($urandom_range(1, 11));
      r = (m_stat != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 9) != 0);
      c = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      step(r, w, ic, c, a, b, {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
